// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive front end in the pll_clk domain.
//
// Synchronises the raw serial line, frames 8N1 bytes with a mid-bit sampling
// counter, and buffers received bytes in a show-ahead FIFO. The FIFO drains
// over a valid/ready stream.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data and stop bits, plus the parity_err port.
//
// Parameters:
//   CLKS_PER_BIT  pll_clk cycles per bit (>= 4)
//   FIFO_DEPTH    byte entries (power of 2, >= 2)
//
// Ports:
//   pll_clk     in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_in       in   raw asynchronous serial line, idles high
//   out_data    out  FIFO head byte, 0x00 while empty
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer accepts head when out_valid && out_ready
//   frame_err   out  one-cycle pulse: stop bit sampled 0
//   overrun     out  one-cycle pulse: good byte dropped, FIFO full
//   parity_err  out  one-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)

module uart_rx_deser #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       pll_clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [OccW-1:0] FullOcc  = OccW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  // Input synchroniser
  logic sync1_q, sync2_q;
  logic rx_s;

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Framing FSM
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            sample;
  logic            push_req;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
  logic            parity_err_q;
`endif

  assign sample = (cnt_q == '0);

  always_comb begin
    push_req = (state_q == StStop) && sample && rx_s;
`ifdef UART_RX_PARITY_EN
    push_req = push_req && !par_bad_q;
`endif
  end

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            cnt_q   <= HalfLoad;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (!sample) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!rx_s) begin
            cnt_q     <= FullLoad;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            // Start bit gone by mid-bit: a glitch, not a frame
            state_q <= StIdle;
          end
        end
        StData: begin
          if (!sample) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            shift_q   <= {rx_s, shift_q[7:1]};
            cnt_q     <= FullLoad;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (!sample) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            // Even parity: data bits plus parity bit must XOR to 0
            par_bad_q <= rx_s ^ (^shift_q);
            cnt_q     <= FullLoad;
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          if (!sample) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!rx_s) begin
            // Framing error outranks a parity error
            frame_err_q <= 1'b1;
            state_q     <= StBreak;
          end else begin
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_bad_q;
`endif
            state_q <= StIdle;
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  // Show-ahead FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q;
  logic            empty, full, pop, push, overrun_d, overrun_q;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FullOcc);
  assign pop   = out_ready && !empty;
  // When full, a same-cycle pop frees the head slot that the write lands in
  assign push      = push_req && (!full || pop);
  assign overrun_d = push_req && full && !pop;

  always_ff @(posedge pll_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      occ_q <= occ_q + OccW'(push) - OccW'(pop);
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

  localparam int unsigned Cpb   = 8;
  localparam int unsigned Depth = 4;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_deser #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .pll_clk   (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] sb[$];
  logic [8:0] exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted byte
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (out_valid && out_ready) begin
        // 0x100 can never match an 8-bit byte, so an unexpected pop fails
        exp_v = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
        check("pop_data", {23'b0, 1'b0, out_data}, {23'b0, exp_v});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit);
    drive_bit(1'b1);
  endtask
`endif

  int v0;

  initial begin
    rst       = 1'b1;
    rx_in     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'h00);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Single byte, consumer always ready
    v0 = valid_cycles;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_drained", 32'(sb.size()), 32'd0);
    check("a5_valid_len", 32'(valid_cycles - v0), 32'd1);
    check("a5_no_fe", 32'(fe_cnt), 32'd0);
    check("a5_no_ov", 32'(ov_cnt), 32'd0);

    // Short low glitch on an idle line
    v0 = valid_cycles;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    check("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt), 32'd0);

    // Framing error, then a good byte
    v0 = valid_cycles;
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("fe_pulse", 32'(fe_cnt), 32'd1);
    check("fe_no_push", 32'(valid_cycles - v0), 32'd0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("after_fe_drained", 32'(sb.size()), 32'd0);
    check("after_fe_fe", 32'(fe_cnt), 32'd1);

    // Fill the FIFO with the consumer stalled, overrun on the fifth byte
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    idle(20);
    check("fill_no_ov", 32'(ov_cnt), 32'd0);
    check("fill_valid", {31'b0, out_valid}, 32'd1);
    check("fill_head", {24'b0, out_data}, 32'h01);
    send_frame(8'h05, 1'b1);
    idle(20);
    check("ov_pulse", 32'(ov_cnt), 32'd1);
    check("ov_head_stable", {24'b0, out_data}, 32'h01);
    for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
    out_ready = 1'b1;
    idle(10);
    check("drain_all", 32'(sb.size()), 32'd0);
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-frame flushes the FIFO and the partial byte
    out_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(20);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    drive_bit(1'b0);
    rx_in = 1'b1;
    repeat (4 * Cpb + Cpb / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_data", {24'b0, out_data}, 32'h00);
    idle(40);
    check("post_rst_still_empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(20);
    check("rst_42_drained", 32'(sb.size()), 32'd0);
    check("rst_42_empty", {31'b0, out_valid}, 32'd0);

    // Back-to-back frames with no idle gap
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h5A);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("b2b_drained", 32'(sb.size()), 32'd0);
    check("b2b_fe", 32'(fe_cnt), 32'd1);
    check("b2b_ov", 32'(ov_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1
    v0 = valid_cycles;
    send_par_frame(8'h07, 1'b0);
    idle(20);
    check("par_bad_pulse", 32'(pe_cnt), 32'd1);
    check("par_bad_no_push", 32'(valid_cycles - v0), 32'd0);
    sb.push_back(8'h07);
    send_par_frame(8'h07, 1'b1);
    idle(20);
    check("par_good_drained", 32'(sb.size()), 32'd0);
    check("par_good_pe", 32'(pe_cnt), 32'd1);
`else
    check("no_parity_pulses", 32'(pe_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
